ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory stage of the in-order RISC-V core. Each cycle it captures the execute-stage result and load/store request, or holds it, inserts a bubble, or flushes, according to the global stall vector and flush line. On capture it checks load/store address alignment. It presents a registered, stable bundle to the memory stage for a full cycle.

---
 rtl/ex_mem_if.sv | 36 +++
 rtl/ex_mem.sv | 109 ++++++++++
 tb/tb_ex_mem.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// Execute-to-memory stage bundle: execute-side request fields and their registered memory-side copies.
interface ex_mem_if;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [4:0]  ex_reg_waddr_i;
  logic        ex_reg_we_i;
  logic [31:0] ex_reg_wdata_i;
  logic [3:0]  ex_mem_op_i;
  logic [31:0] ex_mem_addr_i;
  logic [31:0] ex_mem_wdata_i;

  logic        mem_valid_o;
  logic [31:0] mem_pc_o;
  logic [4:0]  mem_reg_waddr_o;
  logic        mem_reg_we_o;
  logic [31:0] mem_reg_wdata_o;
  logic [3:0]  mem_op_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_misalign_o;

  // The execute stage drives the request and observes the registered bundle.
  modport master (
    output ex_valid_i, ex_pc_i, ex_reg_waddr_i, ex_reg_we_i, ex_reg_wdata_i,
           ex_mem_op_i, ex_mem_addr_i, ex_mem_wdata_i,
    input  mem_valid_o, mem_pc_o, mem_reg_waddr_o, mem_reg_we_o, mem_reg_wdata_o,
           mem_op_o, mem_addr_o, mem_wdata_o, mem_misalign_o
  );

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_reg_waddr_i, ex_reg_we_i, ex_reg_wdata_i,
           ex_mem_op_i, ex_mem_addr_i, ex_mem_wdata_i,
    output mem_valid_o, mem_pc_o, mem_reg_waddr_o, mem_reg_we_o, mem_reg_wdata_o,
           mem_op_o, mem_addr_o, mem_wdata_o, mem_misalign_o
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: capture, hold, bubble or flush the execute result each cycle,
// legalising the memory op and flagging misaligned loads/stores on capture.
module ex_mem (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       flush,
  ex_mem_if.slave    bus
);

  localparam logic [3:0] OpNone = 4'h0;
  localparam logic [3:0] OpLb   = 4'h1;
  localparam logic [3:0] OpLh   = 4'h2;
  localparam logic [3:0] OpLw   = 4'h3;
  localparam logic [3:0] OpLbu  = 4'h4;
  localparam logic [3:0] OpLhu  = 4'h5;
  localparam logic [3:0] OpSb   = 4'h8;
  localparam logic [3:0] OpSh   = 4'h9;
  localparam logic [3:0] OpSw   = 4'hA;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  reg_waddr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        misalign;
  } stage_t;

  localparam stage_t StageClear = '0;

  stage_t stage_d, stage_q, captured;
  logic [3:0] op_legal;
  logic       half_op, word_op, misalign;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Unknown op codes are demoted to no memory access.
  always_comb begin
    op_legal = OpNone;
    half_op  = 1'b0;
    word_op  = 1'b0;
    unique case (bus.ex_mem_op_i)
      OpLb, OpLbu, OpSb: op_legal = bus.ex_mem_op_i;
      OpLh, OpLhu, OpSh: begin
        op_legal = bus.ex_mem_op_i;
        half_op  = 1'b1;
      end
      OpLw, OpSw: begin
        op_legal = bus.ex_mem_op_i;
        word_op  = 1'b1;
      end
      default: op_legal = OpNone;
    endcase
  end

  assign misalign = (half_op && bus.ex_mem_addr_i[0]) ||
                    (word_op && (bus.ex_mem_addr_i[1:0] != 2'b00));

  // A misaligned access stays valid so the trap logic sees its pc and address.
  always_comb begin
    captured = StageClear;
    if (bus.ex_valid_i) begin
      captured.valid     = 1'b1;
      captured.pc        = bus.ex_pc_i;
      captured.reg_waddr = bus.ex_reg_waddr_i;
      captured.reg_we    = bus.ex_reg_we_i && !misalign;
      captured.reg_wdata = bus.ex_reg_wdata_i;
      captured.op        = misalign ? OpNone : op_legal;
      captured.addr      = bus.ex_mem_addr_i;
      captured.wdata     = bus.ex_mem_wdata_i;
      captured.misalign  = misalign;
    end
  end

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = StageClear;
    end else if (stall[3] && !stall[4]) begin
      stage_d = StageClear;
    end else if (!stall[3]) begin
      stage_d = captured;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= StageClear;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.mem_valid_o     = stage_q.valid;
  assign bus.mem_pc_o        = stage_q.pc;
  assign bus.mem_reg_waddr_o = stage_q.reg_waddr;
  assign bus.mem_reg_we_o    = stage_q.reg_we;
  assign bus.mem_reg_wdata_o = stage_q.reg_wdata;
  assign bus.mem_op_o        = stage_q.op;
  assign bus.mem_addr_o      = stage_q.addr;
  assign bus.mem_wdata_o     = stage_q.wdata;
  assign bus.mem_misalign_o  = stage_q.misalign;

endmodule

// File: tb/tb_ex_mem.sv
// Randomised and directed bench for ex_mem against a behavioural next-cycle model.
module tb_ex_mem;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_if bus ();

  ex_mem dut (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        mis;
  } exp_t;

  exp_t exp_q;
  exp_t zero_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Access size in bytes for a legal op, 0 for anything that is not a memory access.
  function automatic int access_size(input logic [3:0] op);
    case (op)
      4'h1, 4'h4, 4'h8: return 1;
      4'h2, 4'h5, 4'h9: return 2;
      4'h3, 4'hA:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic exp_t model_next(input exp_t cur);
    exp_t n;
    int   sz;
    n = zero_st;
    if (!rst || flush) return n;
    if (stall[3] && stall[4]) return cur;
    if (stall[3]) return n;
    if (!bus.ex_valid_i) return n;
    sz      = access_size(bus.ex_mem_op_i);
    n.valid = 1'b1;
    n.pc    = bus.ex_pc_i;
    n.waddr = bus.ex_reg_waddr_i;
    n.we    = bus.ex_reg_we_i;
    n.wdata = bus.ex_reg_wdata_i;
    n.op    = (sz == 0) ? 4'h0 : bus.ex_mem_op_i;
    n.addr  = bus.ex_mem_addr_i;
    n.sdata = bus.ex_mem_wdata_i;
    n.mis   = (sz > 1) && ((bus.ex_mem_addr_i % sz) != 0);
    if (n.mis) begin
      n.op = 4'h0;
      n.we = 1'b0;
    end
    return n;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(bus.mem_valid_o), 32'(exp_q.valid));
    check({tag, ".pc"},    bus.mem_pc_o, exp_q.pc);
    check({tag, ".waddr"}, 32'(bus.mem_reg_waddr_o), 32'(exp_q.waddr));
    check({tag, ".we"},    32'(bus.mem_reg_we_o), 32'(exp_q.we));
    check({tag, ".wdata"}, bus.mem_reg_wdata_o, exp_q.wdata);
    check({tag, ".op"},    32'(bus.mem_op_o), 32'(exp_q.op));
    check({tag, ".addr"},  bus.mem_addr_o, exp_q.addr);
    check({tag, ".sdata"}, bus.mem_wdata_o, exp_q.sdata);
    check({tag, ".mis"},   32'(bus.mem_misalign_o), 32'(exp_q.mis));
  endtask

  // Inputs were driven at the previous negedge; update the model on the same edge as the DUT.
  task automatic step(input string tag);
    @(posedge clk);
    exp_q = model_next(exp_q);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                       input logic we, input logic [31:0] wd, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] sd);
    bus.ex_valid_i     = v;
    bus.ex_pc_i        = pc;
    bus.ex_reg_waddr_i = wa;
    bus.ex_reg_we_i    = we;
    bus.ex_reg_wdata_i = wd;
    bus.ex_mem_op_i    = op;
    bus.ex_mem_addr_i  = addr;
    bus.ex_mem_wdata_i = sd;
  endtask

  task automatic drive_random(input logic v);
    drive(v, $urandom, 5'($urandom), 1'($urandom), $urandom, 4'($urandom),
          $urandom, $urandom);
  endtask

  initial begin
    logic [31:0] pc_hist[$];
    logic [31:0] pc_in;
    logic [5:0]  stall_pick;
    zero_st = '{valid: 1'b0, pc: '0, waddr: '0, we: 1'b0, wdata: '0, op: '0,
                addr: '0, sdata: '0, mis: 1'b0};
    exp_q = zero_st;

    // Reset with live, nonzero inputs
    rst = 1'b0; stall = 6'd0; flush = 1'b0;
    drive(1'b1, 32'h44, 5'd3, 1'b1, 32'hFFFF_0000, 4'h3, 32'h40, 32'h55);
    @(negedge clk);
    step("rst0");
    step("rst1");
    check("rst_valid_zero", 32'(bus.mem_valid_o), 32'd0);

    rst = 1'b1;
    drive(1'b1, 32'h80, 5'd5, 1'b1, 32'h1234_5678, 4'h0, 32'h0, 32'h0);
    step("first_cap");
    check("first_cap_wdata", bus.mem_reg_wdata_o, 32'h1234_5678);
    check("first_cap_valid", 32'(bus.mem_valid_o), 32'd1);

    // Hold, then bubble
    drive(1'b1, 32'h84, 5'd2, 1'b0, 32'h0, 4'hA, 32'h100, 32'hCAFE_BABE);
    step("sw_cap");
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_random(1'b1);
      step("hold");
    end
    check("hold_sdata", bus.mem_wdata_o, 32'hCAFE_BABE);
    stall = 6'b001111;
    step("bubble");
    check("bubble_valid", 32'(bus.mem_valid_o), 32'd0);

    // Misalignment
    stall = 6'd0;
    drive(1'b1, 32'h90, 5'd7, 1'b1, 32'h9, 4'h3, 32'h1002, 32'h0);
    step("lw_mis");
    check("lw_mis_flag", 32'(bus.mem_misalign_o), 32'd1);
    check("lw_mis_op", 32'(bus.mem_op_o), 32'd0);
    check("lw_mis_addr", bus.mem_addr_o, 32'h1002);
    drive(1'b1, 32'h94, 5'd7, 1'b1, 32'h9, 4'h2, 32'h1002, 32'h0);
    step("lh_ok");
    check("lh_ok_op", 32'(bus.mem_op_o), 32'd2);
    drive(1'b1, 32'h98, 5'd0, 1'b0, 32'h0, 4'h8, 32'h1003, 32'hAB);
    step("sb_ok");
    check("sb_ok_mis", 32'(bus.mem_misalign_o), 32'd0);

    // Flush priority over hold and over a valid input
    drive(1'b1, 32'h9C, 5'd0, 1'b0, 32'h0, 4'h9, 32'h20, 32'h77);
    step("sh_cap");
    stall = 6'b011111; flush = 1'b1;
    step("flush_hold");
    check("flush_hold_addr", bus.mem_addr_o, 32'h0);
    stall = 6'd0;
    drive(1'b1, 32'hA0, 5'd4, 1'b1, 32'h1, 4'h3, 32'h40, 32'h0);
    step("flush_in");
    flush = 1'b0;

    // Invalid input and illegal op
    drive(1'b0, 32'hA4, 5'd9, 1'b1, 32'h5, 4'h3, 32'h40, 32'h0);
    step("invalid");
    drive(1'b1, 32'hA8, 5'd6, 1'b1, 32'h66, 4'h6, 32'h3, 32'h99);
    step("illegal_op");
    check("illegal_op_valid", 32'(bus.mem_valid_o), 32'd1);
    check("illegal_op_pc", bus.mem_pc_o, 32'hA8);

    // Back-to-back stream, in-order check against an input queue
    for (int i = 0; i < 8; i++) begin
      drive_random(1'b1);
      pc_hist.push_back(bus.ex_pc_i);
      step("stream");
      pc_in = pc_hist.pop_front();
      check("stream_order", bus.mem_pc_o, pc_in);
    end

    // Random mix of stalls, flushes, resets and ops
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       stall_pick = 6'b011111;
        1:       stall_pick = 6'b001111;
        2:       stall_pick = 6'b010000;
        default: stall_pick = 6'd0;
      endcase
      stall = stall_pick;
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 29) != 0);
      drive_random(($urandom_range(0, 4) != 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
